// File: rtl/clahe_frame_ctrl.sv
// Frame-level sequencer for CLAHE: pixel/tile coordinates, frame geometry check,
// config shadowing and histogram ping-pong / CDF handshake control.
module clahe_frame_ctrl #(
  parameter int H_DISP = 1280,
  parameter int V_DISP = 720,
  parameter int TILE_W = 320,
  parameter int TILE_H = 180
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        in_vsync,
  input  logic        in_href,
  input  logic        cfg_clahe_enable,
  input  logic        cfg_enable_interp,
  input  logic [11:0] cfg_clip_threshold,
  input  logic        cdf_done,
  output logic        clahe_enable,
  output logic        enable_interp,
  output logic [11:0] clip_threshold,
  output logic [10:0] x_cnt,
  output logic [9:0]  y_cnt,
  output logic [1:0]  tile_x,
  output logic [1:0]  tile_y,
  output logic        bank_sel,
  output logic        cdf_start,
  output logic        cdf_valid,
  output logic        frame_err,
  output logic        cdf_overrun,
  output logic [15:0] frame_cnt,
  output logic        busy,
  output logic [1:0]  state_dbg
);

  localparam int TXW = $clog2(TILE_W + 1);
  localparam int TYW = $clog2(TILE_H + 1);
  localparam logic [TXW-1:0] TX_LAST = TXW'(TILE_W - 1);
  localparam logic [TYW-1:0] TY_LAST = TYW'(TILE_H - 1);
  localparam logic [10:0]    H_LEN   = 11'(H_DISP);
  localparam logic [9:0]     V_LEN   = 10'(V_DISP);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    CDF_WAIT = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic           vsync_d, href_d;
  logic           vsync_rise, vsync_fall, href_fall;
  logic           pix, line_end, frame_start, frame_end, frame_ok;
  logic           line_err;
  logic [TXW-1:0] tx_sub;
  logic [TYW-1:0] ty_sub;

  // vsync_d resets high so a frame already running at reset release is not
  // mistaken for a fresh vsync rising edge.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vsync_d <= 1'b1;
      href_d  <= 1'b0;
    end else begin
      vsync_d <= in_vsync;
      href_d  <= in_href;
    end
  end

  assign vsync_rise  = in_vsync & ~vsync_d;
  assign vsync_fall  = ~in_vsync & vsync_d;
  assign href_fall   = ~in_href & href_d;
  assign frame_start = vsync_rise & (state != ACTIVE);
  assign frame_end   = vsync_fall & (state == ACTIVE);
  assign pix         = (state == ACTIVE) & in_vsync & in_href;
  assign line_end    = (state == ACTIVE) & in_vsync & href_fall;
  // A line still open at vsync fall (x_cnt != 0) counts as a geometry error.
  assign frame_ok    = ~line_err & (y_cnt == V_LEN) & (x_cnt == 11'd0);
  assign busy        = (state != IDLE);
  assign state_dbg   = state;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (vsync_rise) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (vsync_fall) state_nxt = frame_ok ? CDF_WAIT : IDLE;
      end
      CDF_WAIT: begin
        if (vsync_rise)    state_nxt = ACTIVE;
        else if (cdf_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shadowed config and pixel/line/tile coordinate counters.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      clahe_enable   <= 1'b0;
      enable_interp  <= 1'b0;
      clip_threshold <= 12'd0;
      x_cnt          <= 11'd0;
      y_cnt          <= 10'd0;
      tile_x         <= 2'd0;
      tile_y         <= 2'd0;
      tx_sub         <= '0;
      ty_sub         <= '0;
      line_err       <= 1'b0;
    end else if (frame_start) begin
      clahe_enable   <= cfg_clahe_enable;
      enable_interp  <= cfg_enable_interp;
      clip_threshold <= cfg_clip_threshold;
      x_cnt          <= 11'd0;
      y_cnt          <= 10'd0;
      tile_x         <= 2'd0;
      tile_y         <= 2'd0;
      tx_sub         <= '0;
      ty_sub         <= '0;
      line_err       <= 1'b0;
    end else begin
      if (pix) begin
        if (x_cnt != 11'h7FF) x_cnt <= x_cnt + 11'd1;
        if (tx_sub == TX_LAST) begin
          tx_sub <= '0;
          if (tile_x != 2'd3) tile_x <= tile_x + 2'd1;
        end else begin
          tx_sub <= tx_sub + 1'b1;
        end
      end
      if (line_end) begin
        if (x_cnt != H_LEN) line_err <= 1'b1;
        x_cnt  <= 11'd0;
        tile_x <= 2'd0;
        tx_sub <= '0;
        if (y_cnt != 10'h3FF) y_cnt <= y_cnt + 10'd1;
        if (ty_sub == TY_LAST) begin
          ty_sub <= '0;
          if (tile_y != 2'd3) tile_y <= tile_y + 2'd1;
        end else begin
          ty_sub <= ty_sub + 1'b1;
        end
      end
    end
  end

  // cdf_start requests the CDF engine on the bank just filled (~bank_sel after
  // the toggle); cdf_done closes that request only while in CDF_WAIT.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      bank_sel    <= 1'b0;
      cdf_start   <= 1'b0;
      frame_err   <= 1'b0;
      cdf_valid   <= 1'b0;
      cdf_overrun <= 1'b0;
      frame_cnt   <= 16'd0;
    end else begin
      cdf_start <= frame_end & frame_ok;
      frame_err <= frame_end & ~frame_ok;
      if (frame_end && frame_ok) begin
        bank_sel  <= ~bank_sel;
        frame_cnt <= frame_cnt + 16'd1;
        cdf_valid <= 1'b0;
      end
      if (state == CDF_WAIT && cdf_done) cdf_valid <= 1'b1;
      if (state == CDF_WAIT && vsync_rise && !cdf_done) cdf_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_clahe_frame_ctrl.sv
// Directed + randomized frame sequences for clahe_frame_ctrl on a reduced
// 40x12 geometry (10x3 tiles), checked against a frame-level reference model.
module tb_clahe_frame_ctrl;

  localparam int H  = 40;
  localparam int V  = 12;
  localparam int TW = 10;
  localparam int TH = 3;

  logic        pclk = 1'b0;
  logic        rst;
  logic        in_vsync, in_href;
  logic        cfg_clahe_enable, cfg_enable_interp;
  logic [11:0] cfg_clip_threshold;
  logic        cdf_done;
  logic        clahe_enable, enable_interp;
  logic [11:0] clip_threshold;
  logic [10:0] x_cnt;
  logic [9:0]  y_cnt;
  logic [1:0]  tile_x, tile_y;
  logic        bank_sel, cdf_start, cdf_valid, frame_err, cdf_overrun, busy;
  logic [15:0] frame_cnt;
  logic [1:0]  state_dbg;

  clahe_frame_ctrl #(.H_DISP(H), .V_DISP(V), .TILE_W(TW), .TILE_H(TH)) dut (
    .pclk(pclk), .rst(rst), .in_vsync(in_vsync), .in_href(in_href),
    .cfg_clahe_enable(cfg_clahe_enable), .cfg_enable_interp(cfg_enable_interp),
    .cfg_clip_threshold(cfg_clip_threshold), .cdf_done(cdf_done),
    .clahe_enable(clahe_enable), .enable_interp(enable_interp),
    .clip_threshold(clip_threshold), .x_cnt(x_cnt), .y_cnt(y_cnt),
    .tile_x(tile_x), .tile_y(tile_y), .bank_sel(bank_sel), .cdf_start(cdf_start),
    .cdf_valid(cdf_valid), .frame_err(frame_err), .cdf_overrun(cdf_overrun),
    .frame_cnt(frame_cnt), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: frame-level bookkeeping
  bit          m_bank, m_valid, m_overrun, m_wait, m_active, m_bad;
  bit          m_en, m_interp;
  logic [11:0] m_clip;
  logic [15:0] m_cnt;
  int          m_y;
  logic [1:0]  exp_q[$];  // expected {cdf_start, frame_err} per vsync fall

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic model_reset();
    m_bank = 0; m_valid = 0; m_overrun = 0; m_wait = 0; m_active = 0; m_bad = 0;
    m_en = 0; m_interp = 0; m_clip = '0; m_cnt = '0; m_y = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_en"}, 32'(clahe_enable), 0);
    chk({tag, "_interp"}, 32'(enable_interp), 0);
    chk({tag, "_clip"}, 32'(clip_threshold), 0);
    chk({tag, "_x"}, 32'(x_cnt), 0);
    chk({tag, "_y"}, 32'(y_cnt), 0);
    chk({tag, "_tx"}, 32'(tile_x), 0);
    chk({tag, "_ty"}, 32'(tile_y), 0);
    chk({tag, "_bank"}, 32'(bank_sel), 0);
    chk({tag, "_start"}, 32'(cdf_start), 0);
    chk({tag, "_valid"}, 32'(cdf_valid), 0);
    chk({tag, "_err"}, 32'(frame_err), 0);
    chk({tag, "_ovr"}, 32'(cdf_overrun), 0);
    chk({tag, "_fcnt"}, 32'(frame_cnt), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_bank"}, 32'(bank_sel), 32'(m_bank));
    chk({tag, "_fcnt"}, 32'(frame_cnt), 32'(m_cnt));
    chk({tag, "_valid"}, 32'(cdf_valid), 32'(m_valid));
    chk({tag, "_ovr"}, 32'(cdf_overrun), 32'(m_overrun));
    chk({tag, "_busy"}, 32'(busy), 32'(m_active || m_wait));
  endtask

  task automatic check_shadow(input string tag);
    chk({tag, "_en"}, 32'(clahe_enable), 32'(m_en));
    chk({tag, "_interp"}, 32'(enable_interp), 32'(m_interp));
    chk({tag, "_clip"}, 32'(clip_threshold), 32'(m_clip));
  endtask

  // driver: vblank with new cfg, then a vsync rising edge (optionally with cdf_done)
  task automatic vsync_rise(input bit en, input bit ip, input logic [11:0] clip, input bit with_done);
    tick();
    in_vsync = 1'b0;
    cfg_clahe_enable = en; cfg_enable_interp = ip; cfg_clip_threshold = clip;
    repeat ($urandom_range(2, 5)) tick();
    @(negedge pclk);
    check_shadow("shadow_hold");
    tick();
    in_vsync = 1'b1;
    cdf_done = with_done;
    if (m_wait) begin
      if (with_done) m_valid = 1;
      else           m_overrun = 1;
    end
    m_wait = 0; m_active = 1; m_y = 0; m_bad = 0;
    m_en = en; m_interp = ip; m_clip = clip;
    tick();
    cdf_done = 1'b0;
    cfg_clip_threshold = 12'($urandom);
    cfg_clahe_enable = 1'($urandom_range(0, 1));
    cfg_enable_interp = 1'($urandom_range(0, 1));
    @(negedge pclk);
    check_shadow("rise_shadow");
    chk("rise_x", 32'(x_cnt), 0);
    chk("rise_y", 32'(y_cnt), 0);
    chk("rise_tile", 32'({tile_x, tile_y}), 0);
    check_status("rise");
  endtask

  // driver: one href line of len pixels followed by a short hblank
  task automatic send_line(input int len);
    int ex, etx, ey, ety;
    for (int i = 0; i < len; i++) begin
      tick();
      in_href = 1'b1;
      @(negedge pclk);
      ex  = m_active ? ((i > 2047) ? 2047 : i) : 0;
      etx = m_active ? (((i / TW) > 3) ? 3 : i / TW) : 0;
      ey  = m_active ? ((m_y > 1023) ? 1023 : m_y) : 0;
      ety = m_active ? (((m_y / TH) > 3) ? 3 : m_y / TH) : 0;
      chk("pix_x", 32'(x_cnt), ex);
      chk("pix_tile_x", 32'(tile_x), etx);
      chk("pix_y", 32'(y_cnt), ey);
      chk("pix_tile_y", 32'(tile_y), ety);
    end
    repeat ($urandom_range(2, 4)) begin
      tick();
      in_href = 1'b0;
    end
    if (m_active) begin
      m_y++;
      if (len != H) m_bad = 1;
    end
    @(negedge pclk);
    ey  = m_active ? ((m_y > 1023) ? 1023 : m_y) : 0;
    ety = m_active ? (((m_y / TH) > 3) ? 3 : m_y / TH) : 0;
    chk("eol_x", 32'(x_cnt), 0);
    chk("eol_tile_x", 32'(tile_x), 0);
    chk("eol_y", 32'(y_cnt), ey);
    chk("eol_tile_y", 32'(tile_y), ety);
    check_shadow("eol_shadow");
  endtask

  // driver: vsync falling edge and frame verdict one cycle later
  task automatic end_frame();
    logic [1:0] e;
    bit good;
    tick();
    in_vsync = 1'b0;
    in_href  = 1'b0;
    if (m_active) begin
      good = !m_bad && (m_y == V);
      if (good) begin
        m_bank = ~m_bank; m_cnt = m_cnt + 16'd1; m_valid = 0; m_wait = 1;
      end
      exp_q.push_back({good, !good});
    end else begin
      exp_q.push_back(2'b00);
    end
    m_active = 0;
    @(negedge pclk);
    chk("start_early", 32'(cdf_start), 0);
    chk("err_early", 32'(frame_err), 0);
    tick();
    @(negedge pclk);
    e = exp_q.pop_front();
    chk("cdf_start", 32'(cdf_start), 32'(e[1]));
    chk("frame_err", 32'(frame_err), 32'(e[0]));
    check_status("vfall");
    tick();
    @(negedge pclk);
    chk("start_width", 32'(cdf_start), 0);
    chk("err_width", 32'(frame_err), 0);
  endtask

  // driver: n idle cycles, then a one-cycle cdf_done
  task automatic wait_done(input int n);
    repeat (n) begin
      tick();
      @(negedge pclk);
      chk("valid_hold", 32'(cdf_valid), 32'(m_valid));
    end
    tick();
    cdf_done = 1'b1;
    if (m_wait) begin
      m_valid = 1; m_wait = 0;
    end
    tick();
    cdf_done = 1'b0;
    @(negedge pclk);
    check_status("done");
  endtask

  task automatic done_pulse_active();
    tick();
    cdf_done = 1'b1;
    tick();
    cdf_done = 1'b0;
    @(negedge pclk);
    check_status("done_ignored");
  endtask

  task automatic good_lines(input int n);
    for (int l = 0; l < n; l++) send_line(H);
  endtask

  initial begin
    rst = 1'b1; in_vsync = 1'b0; in_href = 1'b0; cdf_done = 1'b0;
    cfg_clahe_enable = 1'b1; cfg_enable_interp = 1'b1; cfg_clip_threshold = 12'hABC;
    model_reset();
    repeat (3) tick();
    @(negedge pclk);
    check_zero("por");
    tick();
    rst = 1'b0;

    // nominal frame, clip 600, cfg changed mid-frame has no effect
    vsync_rise(1'b1, 1'b1, 12'd600, 1'b0);
    for (int l = 0; l < V; l++) begin
      if (l == 5) begin
        cfg_clip_threshold = 12'd300;
        cfg_clahe_enable = 1'b0;
      end
      send_line(H);
    end
    end_frame();
    wait_done(50);

    // short line 5 -> geometry error
    vsync_rise(1'b0, 1'b1, 12'd300, 1'b0);
    for (int l = 0; l < V; l++) send_line((l == 5) ? H - 1 : H);
    end_frame();

    // over-long first line saturates x_cnt and tile_x
    vsync_rise(1'b1, 1'b0, 12'($urandom), 1'b0);
    send_line(2050);
    good_lines(V - 1);
    end_frame();

    // cdf_done during ACTIVE is ignored
    vsync_rise(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 12'($urandom), 1'b0);
    good_lines(4);
    done_pulse_active();
    good_lines(V - 4);
    end_frame();

    // next frame without cdf_done -> overrun
    vsync_rise(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 12'($urandom), 1'b0);
    good_lines(V);
    end_frame();

    // rise together with cdf_done, then reset mid-line
    vsync_rise(1'b1, 1'b1, 12'($urandom), 1'b1);
    good_lines(3);
    tick(); in_href = 1'b1;
    tick(); in_href = 1'b1;
    rst = 1'b1;
    #1;
    check_zero("rst_mid");
    tick();
    tick();
    rst = 1'b0;
    in_href = 1'b0;
    model_reset();
    good_lines(V - 3);
    end_frame();

    // clean overrun-free handoff: rise in the same cycle as cdf_done
    vsync_rise(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 12'($urandom), 1'b0);
    good_lines(V);
    end_frame();
    vsync_rise(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 12'($urandom), 1'b1);
    good_lines(V);
    end_frame();
    wait_done($urandom_range(1, 30));

    // randomized frame mix
    for (int k = 0; k < 6; k++) begin
      int kind, nl, badl;
      kind = $urandom_range(0, 3);
      vsync_rise(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 12'($urandom),
                 m_wait && ($urandom_range(0, 1) == 1));
      nl   = (kind == 2) ? V - 1 : (kind == 3) ? V + 2 : V;
      badl = (kind == 1) ? int'($urandom_range(0, V - 1)) : -1;
      for (int l = 0; l < nl; l++)
        send_line((l == badl) ? (($urandom_range(0, 1) == 1) ? H + 1 : H - 1) : H);
      end_frame();
      if ($urandom_range(0, 1) == 1) wait_done($urandom_range(1, 20));
    end

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
